// File: rtl/mac_sequencer.sv
// mac_sequencer: fetches vec_len weight/input pairs, drives one mac_unit and returns the sum on a valid/ready port.
// Optional build macro: MAC_SEQ_RELU_EN (clamp negative results to zero at capture).

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ACC_WIDTH
`define ACC_WIDTH 32
`endif

module mac_sequencer #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 9
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [LEN_WIDTH-1:0]   vec_len,
    input  logic [ADDR_WIDTH-1:0]  w_base,
    input  logic [ADDR_WIDTH-1:0]  x_base,
    output logic                   busy,
    output logic                   w_rd_en,
    output logic [ADDR_WIDTH-1:0]  w_rd_addr,
    input  logic [`DATA_WIDTH-1:0] w_rd_data,
    output logic                   x_rd_en,
    output logic [ADDR_WIDTH-1:0]  x_rd_addr,
    input  logic [`DATA_WIDTH-1:0] x_rd_data,
    output logic                   mac_clear,
    output logic                   mac_enable,
    output logic [`DATA_WIDTH-1:0] mac_weight,
    output logic [`DATA_WIDTH-1:0] mac_input,
    input  logic [`ACC_WIDTH-1:0]  mac_result,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [`ACC_WIDTH-1:0]  res_data,
    output logic                   done
);

    localparam int unsigned DW = `DATA_WIDTH;
    localparam int unsigned AW = `ACC_WIDTH;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        FETCH   = 3'd2,
        DRAIN   = 3'd3,
        CAPTURE = 3'd4,
        HOLD    = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] w_base_q, w_base_d;
    logic [ADDR_WIDTH-1:0] x_base_q, x_base_d;
    logic [ADDR_WIDTH-1:0] w_addr_d, x_addr_d;
    logic                  rd_en_d, clear_d, busy_d, valid_d;
    logic [AW-1:0]         data_d;

    // Memory data feeds the MAC directly; the MAC's enable is aligned by delaying rd_en.
    assign mac_weight = w_rd_data;
    assign mac_input  = x_rd_data;
    assign x_rd_en    = w_rd_en;
    assign done       = res_valid & res_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            w_base_q   <= '0;
            x_base_q   <= '0;
            busy       <= 1'b0;
            w_rd_en    <= 1'b0;
            w_rd_addr  <= '0;
            x_rd_addr  <= '0;
            mac_clear  <= 1'b0;
            mac_enable <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            w_base_q   <= w_base_d;
            x_base_q   <= x_base_d;
            busy       <= busy_d;
            w_rd_en    <= rd_en_d;
            w_rd_addr  <= w_addr_d;
            x_rd_addr  <= x_addr_d;
            mac_clear  <= clear_d;
            mac_enable <= w_rd_en;
            res_valid  <= valid_d;
            res_data   <= data_d;
        end
    end

    // Next-state and next-output logic; outputs are computed one cycle ahead and registered.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        w_base_d = w_base_q;
        x_base_d = x_base_q;
        w_addr_d = w_rd_addr;
        x_addr_d = x_rd_addr;
        rd_en_d  = 1'b0;
        clear_d  = 1'b0;
        valid_d  = res_valid;
        data_d   = res_data;

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d    = vec_len;
                    w_base_d = w_base;
                    x_base_d = x_base;
                    clear_d  = 1'b1;
                    state_d  = CLEAR;
                end
            end
            CLEAR: begin
                cnt_d = '0;
                if (len_q == '0) begin
                    state_d = CAPTURE;
                end else begin
                    rd_en_d  = 1'b1;
                    w_addr_d = w_base_q;
                    x_addr_d = x_base_q;
                    state_d  = FETCH;
                end
            end
            FETCH: begin
                if (cnt_q == len_q - LEN_WIDTH'(1)) begin
                    state_d = DRAIN;
                end else begin
                    cnt_d    = cnt_q + LEN_WIDTH'(1);
                    rd_en_d  = 1'b1;
                    w_addr_d = w_rd_addr + ADDR_WIDTH'(1);
                    x_addr_d = x_rd_addr + ADDR_WIDTH'(1);
                end
            end
            DRAIN: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                valid_d = 1'b1;
`ifdef MAC_SEQ_RELU_EN
                data_d  = mac_result[AW-1] ? '0 : mac_result;
`else
                data_d  = mac_result;
`endif
                state_d = HOLD;
            end
            HOLD: begin
                if (res_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    logic unused_dw;
    assign unused_dw = (DW == 0);

endmodule

// File: tb/tb_mac_sequencer.sv
// Scoreboard bench for mac_sequencer with a behavioural mac_unit and two synchronous-read memories.

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ACC_WIDTH
`define ACC_WIDTH 32
`endif

module tb_mac_sequencer;

    localparam int unsigned DW = `DATA_WIDTH;
    localparam int unsigned AW = `ACC_WIDTH;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [8:0]    vec_len = '0;
    logic [7:0]    w_base = '0;
    logic [7:0]    x_base = '0;
    logic          busy, w_rd_en, x_rd_en, mac_clear, mac_enable, res_valid, done;
    logic [7:0]    w_rd_addr, x_rd_addr;
    logic [DW-1:0] w_rd_data, x_rd_data, mac_weight, mac_input;
    logic [AW-1:0] mac_result, res_data;
    logic          res_ready = 1'b1;

    mac_sequencer #(.ADDR_WIDTH(8), .LEN_WIDTH(9)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .vec_len(vec_len),
        .w_base(w_base), .x_base(x_base), .busy(busy),
        .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
        .x_rd_en(x_rd_en), .x_rd_addr(x_rd_addr), .x_rd_data(x_rd_data),
        .mac_clear(mac_clear), .mac_enable(mac_enable),
        .mac_weight(mac_weight), .mac_input(mac_input), .mac_result(mac_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .done(done)
    );

    always #5 clk = ~clk;

    // Environment: synchronous-read SRAMs and a MAC with no reset of its own.
    logic [DW-1:0]        wmem [256];
    logic [DW-1:0]        xmem [256];
    logic signed [AW-1:0] acc = '0;
    assign mac_result = acc;

    always @(posedge clk) begin
        if (w_rd_en) w_rd_data <= wmem[w_rd_addr];
        if (x_rd_en) x_rd_data <= xmem[x_rd_addr];
        if (mac_clear)       acc <= '0;
        else if (mac_enable) acc <= acc + AW'($signed(mac_weight) * $signed(mac_input));
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard state
    logic signed [AW-1:0] exp_q[$];
    logic [7:0]           exp_w[$];
    logic [7:0]           exp_x[$];
    int                   exp_lat = 0;
    int                   start_cyc = 0;
    int                   en_seen = 0;
    bit                   seen_valid = 0;

    // Monitor: checks read addresses, valid latency and result data on each handshake.
    always @(negedge clk) begin
        if (reset_n) begin
            if (w_rd_en) begin
                chk("x_rd_en_eq", longint'(x_rd_en), 1);
                if (exp_w.size() == 0) begin
                    chk("unexpected_rd", 1, 0);
                end else begin
                    chk("w_rd_addr", longint'(w_rd_addr), longint'(exp_w.pop_front()));
                    chk("x_rd_addr", longint'(x_rd_addr), longint'(exp_x.pop_front()));
                end
            end
            if (mac_enable) en_seen++;
            chk("done_vs_hs", longint'(done), longint'(res_valid && res_ready));
            if (res_valid && !seen_valid) begin
                seen_valid = 1;
                chk("valid_latency", longint'(cyc - start_cyc + 1), longint'(exp_lat));
            end
            if (res_valid && res_ready) begin
                seen_valid = 0;
                if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
                else chk("res_data", longint'($signed(res_data)), longint'(exp_q.pop_front()));
            end
        end
    end

    task automatic run_job(input int len, input int wb, input int xb,
                           input logic signed [AW-1:0] exp, input bit push_result);
        for (int i = 0; i < len; i++) begin
            exp_w.push_back(8'(wb + i));
            exp_x.push_back(8'(xb + i));
        end
        if (push_result) exp_q.push_back(exp);
        exp_lat = (len == 0) ? 3 : len + 4;
        en_seen = 0;
        @(posedge clk); #1;
        vec_len = 9'(len);
        w_base  = 8'(wb);
        x_base  = 8'(xb);
        start   = 1'b1;
        @(posedge clk); #1;
        start_cyc = cyc;
        start     = 1'b0;
        @(negedge clk);
        chk("mac_clear_cycle1", longint'(mac_clear), 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0 && exp_w.size() == 0) return;
        end
        chk("idle_timeout", 1, 0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy", longint'(busy), 0);
        chk("rst_w_rd_en", longint'(w_rd_en), 0);
        chk("rst_x_rd_en", longint'(x_rd_en), 0);
        chk("rst_w_rd_addr", longint'(w_rd_addr), 0);
        chk("rst_x_rd_addr", longint'(x_rd_addr), 0);
        chk("rst_mac_clear", longint'(mac_clear), 0);
        chk("rst_mac_enable", longint'(mac_enable), 0);
        chk("rst_res_valid", longint'(res_valid), 0);
        chk("rst_res_data", longint'(res_data), 0);
        chk("rst_done", longint'(done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [AW-1:0] relu_exp;
        for (int i = 0; i < 256; i++) begin
            wmem[i] = '0;
            xmem[i] = '0;
        end
        // Job 1
        wmem[0] = 8'd1; wmem[1] = 8'd2; wmem[2] = 8'd3; wmem[3] = 8'd4;
        xmem[0] = 8'd5; xmem[1] = 8'd6; xmem[2] = 8'd7; xmem[3] = 8'd8;
        // Job 2
        wmem[20] = -8'sd3; wmem[21] = 8'sd127;
        xmem[20] = 8'sd2;  xmem[21] = -8'sd1;
        // Address wrap job
        wmem[254] = 8'sd10; wmem[255] = -8'sd1;
        xmem[10] = 8'd2; xmem[11] = 8'd3; xmem[12] = 8'd4; xmem[13] = 8'd5;
        // Hold job
        wmem[50] = 8'd7; xmem[50] = 8'd3;
        // Aborted job: large values would leave a visible stale sum
        for (int i = 30; i < 38; i++) begin
            wmem[i] = 8'd5;
            xmem[i] = 8'd5;
        end
        wmem[40] = 8'd2; wmem[41] = 8'd2;
        xmem[40] = 8'd3; xmem[41] = 8'd3;

        #12;
        chk_reset_outputs();
        reset_n = 1'b1;

        // Basic dot product with exact timing: res_valid/done in cycle 8, idle in cycle 9
        run_job(4, 0, 0, 70, 1);
        repeat (7) @(negedge clk);
        chk("t1_valid_c8", longint'(res_valid), 1);
        chk("t1_done_c8", longint'(done), 1);
        @(negedge clk);
        chk("t1_busy_c9", longint'(busy), 0);
        chk("t1_enables", longint'(en_seen), 4);
        wait_idle();

        // Signed operands
`ifdef MAC_SEQ_RELU_EN
        relu_exp = 0;
`else
        relu_exp = -133;
`endif
        run_job(2, 20, 20, relu_exp, 1);
        wait_idle();
        chk("t2_enables", longint'(en_seen), 2);

        // Zero length
        run_job(0, 0, 0, 0, 1);
        wait_idle();
        chk("t3_no_enable", longint'(en_seen), 0);

        // Address wrap: 10*2 + (-1)*3 + 1*4 + 2*5 = 31
        run_job(4, 254, 10, 31, 1);
        wait_idle();

        // Back-pressure with an ignored start during HOLD
        @(posedge clk); #1 res_ready = 1'b0;
        run_job(1, 50, 50, 21, 1);
        for (int i = 0; i < 50 && !res_valid; i++) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                vec_len = 9'd4; w_base = 8'd0; x_base = 8'd0; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            chk("t5_valid_held", longint'(res_valid), 1);
            chk("t5_data_held", longint'($signed(res_data)), 21);
            chk("t5_busy", longint'(busy), 1);
        end
        start = 1'b0;
        @(posedge clk); #1 res_ready = 1'b1;
        @(negedge clk);
        chk("t5_done", longint'(done), 1);
        @(negedge clk);
        chk("t5_idle", longint'(busy), 0);
        chk("t5_valid_low", longint'(res_valid), 0);
        @(negedge clk);
        chk("t5_still_idle", longint'(busy), 0);
        chk("t5_no_read", longint'(w_rd_en), 0);

        // Reset during FETCH of an 8-long job, then a fresh job must not see the stale sum
        run_job(8, 30, 30, 0, 0);
        repeat (3) @(negedge clk);
        chk("t6_in_fetch", longint'(w_rd_en), 1);
        #1 reset_n = 1'b0;
        #1 chk_reset_outputs();
        exp_w.delete();
        exp_x.delete();
        seen_valid = 0;
        repeat (2) @(negedge clk);
        chk_reset_outputs();
        #1 reset_n = 1'b1;
        run_job(2, 40, 40, 12, 1);
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
